// File: rtl/multi_channel_freq_counter.sv
// multi_channel_freq_counter
//
// Counts rising edges on N_CH asynchronous inputs over a programmable gate
// window of gate_len clk cycles, then latches the per-channel counts together
// with a saturation flag and pulses valid for one cycle.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for en (continuous mode) or en & start (single-shot)
//   ST_GATE | gate window open; gate counter and accumulators advance
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   en         in   global enable; low freezes FSM, gate counter, accumulators
//   mode       in   0 = continuous gating, 1 = single-shot
//   start      in   single-shot trigger, honoured only in ST_IDLE
//   gate_len   in   gate length in cycles, sampled at gate start (0 acts as 1)
//   sig_in     in   asynchronous signals under measurement
//   count_out  out  latched counts, channel k at [k*CNT_W +: CNT_W]
//   ovf        out  per-channel saturation flag for the latched gate
//   valid      out  one-cycle strobe, aligned with count_out/ovf update
//   busy       out  high while in ST_GATE

module multi_channel_freq_counter #(
    parameter int N_CH   = 2,
    parameter int CNT_W  = 7,
    parameter int GATE_W = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     start,
    input  logic [GATE_W-1:0]        gate_len,
    input  logic [N_CH-1:0]          sig_in,
    output logic [N_CH*CNT_W-1:0]    count_out,
    output logic [N_CH-1:0]          ovf,
    output logic                     valid,
    output logic                     busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t                   state_q, state_d;
    logic [GATE_W-1:0]        gate_cnt_q, gate_cnt_d;
    logic [GATE_W-1:0]        gate_len_q, gate_len_d;
    logic [CNT_W-1:0]         acc_q [N_CH];
    logic [CNT_W-1:0]         acc_d [N_CH];
    logic [N_CH-1:0]          pend_q, pend_d;
    logic [N_CH*CNT_W-1:0]    count_q, count_d;
    logic [N_CH-1:0]          ovf_q, ovf_d;
    logic                     valid_q, valid_d;

    logic [N_CH-1:0]          sync1_q, sync2_q, sync3_q;
    logic [N_CH-1:0]          edge_det;
    logic [GATE_W-1:0]        gate_len_eff;
    logic                     last_cycle;
    logic                     start_gate;

    assign edge_det     = sync2_q & ~sync3_q;
    assign gate_len_eff = (gate_len == '0) ? GATE_ONE : gate_len;
    assign last_cycle   = (gate_cnt_q == (gate_len_q - GATE_ONE));

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        gate_len_d = gate_len_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        start_gate = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && (!mode || start)) begin
                    state_d    = ST_GATE;
                    start_gate = 1'b1;
                end
            end
            ST_GATE: begin
                if (en) begin
                    if (last_cycle) begin
                        // The final gate cycle's edge is folded straight into
                        // the latched result rather than the accumulator.
                        for (int k = 0; k < N_CH; k++) begin
                            if (edge_det[k] && (acc_q[k] != CNT_MAX)) begin
                                count_d[k*CNT_W +: CNT_W] = acc_q[k] + 1'b1;
                            end else begin
                                count_d[k*CNT_W +: CNT_W] = acc_q[k];
                            end
                            ovf_d[k] = pend_q[k] | (edge_det[k] & (acc_q[k] == CNT_MAX));
                        end
                        valid_d = 1'b1;
                        // Mode is only looked at here, so a change mid-gate
                        // takes effect at the boundary.
                        if (!mode) begin
                            start_gate = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gate_cnt_d = gate_cnt_q + GATE_ONE;
                        for (int k = 0; k < N_CH; k++) begin
                            if (edge_det[k]) begin
                                if (acc_q[k] == CNT_MAX) begin
                                    pend_d[k] = 1'b1;
                                end else begin
                                    acc_d[k] = acc_q[k] + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_gate) begin
            gate_cnt_d = '0;
            gate_len_d = gate_len_eff;
            pend_d     = '0;
            for (int k = 0; k < N_CH; k++) begin
                acc_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            gate_len_q <= '0;
            acc_q      <= '{default: '0};
            pend_q     <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            valid_q    <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            gate_len_q <= gate_len_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            // Synchronizers run regardless of en; edges seen while en is low
            // are simply not consumed by the FSM.
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
        end
    end

    assign count_out = count_q;
    assign ovf       = ovf_q;
    assign valid     = valid_q;
    assign busy      = (state_q == ST_GATE);

endmodule

// File: tb/tb_multi_channel_freq_counter.sv
module tb_multi_channel_freq_counter;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 7;
    localparam int GATE_W = 13;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic                  mode;
    logic                  start;
    logic [GATE_W-1:0]     gate_len;
    logic [N_CH-1:0]       sig_in;
    logic [N_CH*CNT_W-1:0] count_out;
    logic [N_CH-1:0]       ovf;
    logic                  valid;
    logic                  busy;

    multi_channel_freq_counter #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .GATE_W (GATE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .gate_len  (gate_len),
        .sig_in    (sig_in),
        .count_out (count_out),
        .ovf       (ovf),
        .valid     (valid),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    // Pulse generators: one-cycle-high pulse every per* cycles (0 = idle low).
    int per0 = 0;
    int per1 = 0;
    int ctr0 = 0;
    int ctr1 = 0;

    initial begin
        sig_in = '0;
        forever begin
            @(negedge clk);
            sig_in[0] = (per0 != 0) && (ctr0 == 0);
            sig_in[1] = (per1 != 0) && (ctr1 == 0);
            ctr0 = (ctr0 + 1 >= per0) ? 0 : ctr0 + 1;
            ctr1 = (ctr1 + 1 >= per1) ? 0 : ctr1 + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ch(input int k);
        return int'(count_out[k*CNT_W +: CNT_W]);
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts negedges until valid is seen or the budget runs out.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < budget);
    endtask

    typedef struct {
        int glen;
        int p0;
        int p1;
        int e0;
        int e1;
        int eovf;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        int n;
        int prev;
        int nb;
        int nv;

        vecs[0] = '{glen: 100, p0: 10, p1: 25,  e0: 10,  e1: 4,   eovf: 0};
        vecs[1] = '{glen: 50,  p0: 5,  p1: 0,   e0: 10,  e1: 0,   eovf: 0};
        vecs[2] = '{glen: 300, p0: 2,  p1: 3,   e0: 127, e1: 100, eovf: 1};
        vecs[3] = '{glen: 254, p0: 2,  p1: 127, e0: 127, e1: 2,   eovf: 0};
        vecs[4] = '{glen: 256, p0: 2,  p1: 0,   e0: 127, e1: 0,   eovf: 1};
        vecs[5] = '{glen: 13,  p0: 13, p1: 13,  e0: 1,   e1: 1,   eovf: 0};
        vecs[6] = '{glen: 260, p0: 0,  p1: 2,   e0: 0,   e1: 127, eovf: 2};

        reset    = 1'b1;
        en       = 1'b1;
        mode     = 1'b0;
        start    = 1'b0;
        gate_len = GATE_W'(100);
        per0     = 3;
        per1     = 2;
        repeat (4) @(negedge clk);
        chk("reset_count", int'(count_out), 0);
        chk("reset_ovf",   int'(ovf), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy",  int'(busy), 0);

        // Continuous-mode vectors: skip the first gate after reset, then
        // check two full gates for spacing, counts and ovf.
        for (int i = 0; i < NV; i++) begin
            per0     = vecs[i].p0;
            per1     = vecs[i].p1;
            gate_len = GATE_W'(vecs[i].glen);
            mode     = 1'b0;
            en       = 1'b1;
            do_reset(3);
            wait_valid(2 * vecs[i].glen + 20, n);
            chk($sformatf("v%0d_first_valid", i), int'(valid), 1);
            for (int j = 0; j < 2; j++) begin
                wait_valid(vecs[i].glen + 20, n);
                chk($sformatf("v%0d_g%0d_valid", i, j),   int'(valid), 1);
                chk($sformatf("v%0d_g%0d_spacing", i, j), n, vecs[i].glen);
                chk($sformatf("v%0d_g%0d_ch0", i, j),     ch(0), vecs[i].e0);
                chk($sformatf("v%0d_g%0d_ch1", i, j),     ch(1), vecs[i].e1);
                chk($sformatf("v%0d_g%0d_ovf", i, j),     int'(ovf), vecs[i].eovf);
            end
        end

        // Saturating gate followed by a shorter gate with the same input.
        per0     = 2;
        per1     = 0;
        gate_len = GATE_W'(300);
        do_reset(3);
        repeat (2) @(negedge clk);
        gate_len = GATE_W'(100);
        wait_valid(400, n);
        chk("sat_valid", int'(valid), 1);
        chk("sat_ch0",   ch(0), 127);
        chk("sat_ovf",   int'(ovf), 1);
        wait_valid(150, n);
        chk("unsat_spacing", n, 100);
        chk("unsat_ch0",     ch(0), 50);
        chk("unsat_ovf",     int'(ovf), 0);

        // Single-shot with ignored starts during the gate and at its end.
        per0     = 10;
        per1     = 25;
        mode     = 1'b1;
        gate_len = GATE_W'(50);
        do_reset(3);
        nb = 0;
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy)  nb++;
            if (valid) nv++;
        end
        chk("ss_idle_busy",  nb, 0);
        chk("ss_idle_valid", nv, 0);
        start = 1'b1;
        nb = 0;
        nv = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (busy)  nb++;
            if (valid) nv++;
            start = (i == 20) || (i == 50);
        end
        chk("ss_busy_cycles",    nb, 50);
        chk("ss_valid_in_gate",  nv, 0);
        @(negedge clk);
        start = 1'b0;
        chk("ss_valid", int'(valid), 1);
        chk("ss_busy_after", int'(busy), 0);
        chk("ss_ch0", ch(0), 5);
        chk("ss_ch1", ch(1), 2);
        chk("ss_ovf", int'(ovf), 0);
        nb = 0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy)  nb++;
            if (valid) nv++;
        end
        chk("ss_post_busy",  nb, 0);
        chk("ss_post_valid", nv, 0);

        // en low for 20 cycles in the middle of a gate.
        per0     = 10;
        per1     = 20;
        mode     = 1'b0;
        gate_len = GATE_W'(100);
        do_reset(3);
        wait_valid(250, n);
        chk("en_first_valid", int'(valid), 1);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) nv++;
        end
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid) nv++;
        end
        en = 1'b1;
        chk("en_no_valid_early", nv, 0);
        wait_valid(100, n);
        chk("en_valid",   int'(valid), 1);
        chk("en_spacing", n + 60, 120);
        chk("en_ch0",     ch(0), 10);
        chk("en_ch1",     ch(1), 5);

        // Reset at cycle 60 of a gate discards it.
        wait_valid(150, n);
        chk("rst_pre_valid", int'(valid), 1);
        repeat (59) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_count", int'(count_out), 0);
        chk("rst_ovf",   int'(ovf), 0);
        chk("rst_busy",  int'(busy), 0);
        wait_valid(150, n);
        chk("rst_valid",   int'(valid), 1);
        chk("rst_latency", n, 101);
        chk("rst_ch0",     ch(0), 10);
        chk("rst_ch1",     ch(1), 5);

        // gate_len of 0 behaves as a one-cycle gate.
        per0     = 2;
        per1     = 0;
        gate_len = '0;
        do_reset(3);
        wait_valid(20, n);
        chk("g0_first_valid", int'(valid), 1);
        prev = ch(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("g0_valid_%0d", i), int'(valid), 1);
            chk($sformatf("g0_alt_%0d", i),   ch(0) + prev, 1);
            prev = ch(0);
        end
        chk("g0_busy", int'(busy), 1);
        chk("g0_ovf",  int'(ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
